// File: rtl/axi_bridge_pkg.sv
// Shared constants and helpers for the SRAM-like to AXI3 bridge.
package axi_bridge_pkg;
  localparam logic [1:0] BURST_INCR     = 2'b01;
  localparam logic [1:0] RESP_OKAY      = 2'b00;
  localparam logic [3:0] AXI_LEN_SINGLE = 4'd0;
  localparam int         ID_W           = 4;
  localparam int         CNT_W          = 4;

  function automatic int port_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/bridge_wr_scoreboard.sv
// Outstanding-write address CAM; entries kept compacted in age order so the
// lowest matching slot is always the oldest write of a given id.
module bridge_wr_scoreboard
  import axi_bridge_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int NUM_PORTS = 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   alloc,
  input  logic [29:0]            alloc_addr,
  input  logic [ID_W-1:0]        alloc_id,
  input  logic                   free,
  input  logic [ID_W-1:0]        free_id,
  input  logic [30*NUM_PORTS-1:0] lookup_addr,
  output logic [NUM_PORTS-1:0]   hit
);

  logic            ent_v    [DEPTH];
  logic [29:0]     ent_addr [DEPTH];
  logic [ID_W-1:0] ent_id   [DEPTH];
  logic            nxt_v    [DEPTH];
  logic [29:0]     nxt_addr [DEPTH];
  logic [ID_W-1:0] nxt_id   [DEPTH];
  logic            free_hit;
  int              free_idx;
  int              alloc_pos;

  always_comb begin
    free_hit = 1'b0;
    free_idx = 0;
    for (int j = DEPTH - 1; j >= 0; j--) begin
      if (free && ent_v[j] && ent_id[j] == free_id) begin
        free_hit = 1'b1;
        free_idx = j;
      end
    end
    alloc_pos = 0;
    for (int j = 0; j < DEPTH; j++) begin
      if (ent_v[j]) alloc_pos = alloc_pos + 1;
    end
    if (free_hit) alloc_pos = alloc_pos - 1;

    for (int j = 0; j < DEPTH; j++) begin
      nxt_v[j]    = ent_v[j];
      nxt_addr[j] = ent_addr[j];
      nxt_id[j]   = ent_id[j];
    end
    // Close the gap left by the freed entry so age order is preserved.
    if (free_hit) begin
      for (int j = 0; j < DEPTH - 1; j++) begin
        if (j >= free_idx) begin
          nxt_v[j]    = ent_v[j+1];
          nxt_addr[j] = ent_addr[j+1];
          nxt_id[j]   = ent_id[j+1];
        end
      end
      nxt_v[DEPTH-1] = 1'b0;
    end
    for (int j = 0; j < DEPTH; j++) begin
      if (alloc && j == alloc_pos) begin
        nxt_v[j]    = 1'b1;
        nxt_addr[j] = alloc_addr;
        nxt_id[j]   = alloc_id;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < DEPTH; j++) begin
      if (!resetn) begin
        ent_v[j]    <= 1'b0;
        ent_addr[j] <= '0;
        ent_id[j]   <= '0;
      end else begin
        ent_v[j]    <= nxt_v[j];
        ent_addr[j] <= nxt_addr[j];
        ent_id[j]   <= nxt_id[j];
      end
    end
  end

  // A write granted this cycle already blocks a same-word read.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      hit[p] = alloc && (alloc_addr == lookup_addr[30*p +: 30]);
      for (int j = 0; j < DEPTH; j++) begin
        if (ent_v[j] && ent_addr[j] == lookup_addr[30*p +: 30]) hit[p] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/axi_sram_bridge_mp.sv
// NUM_PORTS SRAM-like masters sharing one AXI3 master; single-beat transfers,
// port index carried on arid/awid, RAW hazards blocked by the write scoreboard.
module axi_sram_bridge_mp
  import axi_bridge_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int MAX_OUTST = 4,
  parameter int ARB_RR    = 0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NUM_PORTS-1:0]    sram_req,
  input  logic [NUM_PORTS-1:0]    sram_wr,
  input  logic [2*NUM_PORTS-1:0]  sram_size,
  input  logic [32*NUM_PORTS-1:0] sram_addr,
  input  logic [4*NUM_PORTS-1:0]  sram_wstrb,
  input  logic [32*NUM_PORTS-1:0] sram_wdata,
  output logic [NUM_PORTS-1:0]    sram_addr_ok,
  output logic [NUM_PORTS-1:0]    sram_data_ok,
  output logic [31:0]             sram_rdata,
  output logic                    bus_err,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  localparam int PW = port_idx_w(NUM_PORTS);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

  logic [CNT_W-1:0]     rd_cnt, wr_cnt;
  logic [PW-1:0]        rd_last, wr_last;
  logic [NUM_PORTS-1:0] rd_elig, wr_elig, rd_gnt, wr_gnt, sb_hit;
  logic [NUM_PORTS-1:0] r_hit, b_hit, p_hit;
  logic [PW:0]          rd_pick, wr_pick;
  logic [31:0]          ar_addr_n, aw_addr_n, w_data_n;
  logic [ID_W-1:0]      ar_id_n, aw_id_n, pend_id;
  logic [2:0]           ar_size_n, aw_size_n;
  logic [3:0]           w_strb_n;
  logic [30*NUM_PORTS-1:0] lookup_addr;
  logic                 pend, r_fire, b_conflict, pend_fire, rd_dec, wr_dec;

  assign arlen   = AXI_LEN_SINGLE;
  assign awlen   = AXI_LEN_SINGLE;
  assign arburst = BURST_INCR;
  assign awburst = BURST_INCR;
  assign arlock  = '0;
  assign awlock  = '0;
  assign arcache = '0;
  assign awcache = '0;
  assign arprot  = '0;
  assign awprot  = '0;
  assign wlast   = 1'b1;
  assign rready  = 1'b1;
  assign bready  = 1'b1;
  assign wid     = awid;
  assign sram_rdata = rdata;

  // Returns {valid, index}; fixed mode favours the highest index, RR the first after last.
  function automatic logic [PW:0] pick(input logic [NUM_PORTS-1:0] elig, input logic [PW-1:0] last);
    logic [PW:0] r;
    r = '0;
    if (ARB_RR != 0) begin
      for (int k = NUM_PORTS; k >= 1; k--)
        for (int i = 0; i < NUM_PORTS; i++)
          if (elig[i] && i == (int'(last) + k) % NUM_PORTS) r = {1'b1, PW'(i)};
    end else begin
      for (int i = 0; i < NUM_PORTS; i++)
        if (elig[i]) r = {1'b1, PW'(i)};
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      rd_elig[i] = resetn && sram_req[i] && !sram_wr[i] && (!arvalid || arready)
                   && (rd_cnt < MAX_CNT) && !sb_hit[i];
      wr_elig[i] = resetn && sram_req[i] && sram_wr[i] && !awvalid && !wvalid
                   && (wr_cnt < MAX_CNT);
      lookup_addr[30*i +: 30] = sram_addr[32*i+2 +: 30];
    end
  end

  assign rd_pick = pick(rd_elig, rd_last);
  assign wr_pick = pick(wr_elig, wr_last);

  always_comb begin
    rd_gnt = '0; ar_addr_n = '0; ar_id_n = '0; ar_size_n = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (rd_pick[PW] && rd_pick[PW-1:0] == PW'(i)) begin
        rd_gnt[i] = 1'b1;
        ar_addr_n = sram_addr[32*i +: 32];
        ar_id_n   = ID_W'(i);
        ar_size_n = {1'b0, sram_size[2*i +: 2]};
      end
    end
  end

  always_comb begin
    wr_gnt = '0; aw_addr_n = '0; aw_id_n = '0; aw_size_n = '0; w_data_n = '0; w_strb_n = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (wr_pick[PW] && wr_pick[PW-1:0] == PW'(i)) begin
        wr_gnt[i] = 1'b1;
        aw_addr_n = sram_addr[32*i +: 32];
        aw_id_n   = ID_W'(i);
        aw_size_n = {1'b0, sram_size[2*i +: 2]};
        w_data_n  = sram_wdata[32*i +: 32];
        w_strb_n  = sram_wstrb[4*i +: 4];
      end
    end
  end

  assign sram_addr_ok = rd_gnt | wr_gnt;

  bridge_wr_scoreboard #(.DEPTH(MAX_OUTST), .NUM_PORTS(NUM_PORTS)) u_sb (
    .clk(clk), .resetn(resetn),
    .alloc(wr_pick[PW]), .alloc_addr(aw_addr_n[31:2]), .alloc_id(aw_id_n),
    .free(bvalid), .free_id(bid),
    .lookup_addr(lookup_addr), .hit(sb_hit)
  );

  // A B response colliding with an R (or pending B) on the same port waits one cycle.
  assign r_fire = rvalid && rlast;
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      r_hit[i] = r_fire && rid == ID_W'(i);
      b_hit[i] = bvalid && bid == ID_W'(i);
      p_hit[i] = pend && pend_id == ID_W'(i);
    end
  end
  assign pend_fire    = |(p_hit & ~r_hit);
  assign b_conflict   = |(b_hit & (r_hit | p_hit));
  assign sram_data_ok = r_hit | (p_hit & ~r_hit) | (b_conflict ? '0 : b_hit);
  assign rd_dec       = r_fire && rd_cnt != '0;
  assign wr_dec       = bvalid && wr_cnt != '0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      arvalid <= 1'b0; araddr <= '0; arid <= '0; arsize <= '0;
      awvalid <= 1'b0; awaddr <= '0; awid <= '0; awsize <= '0;
      wvalid  <= 1'b0; wdata  <= '0; wstrb <= '0;
      rd_cnt  <= '0;   wr_cnt <= '0;
      rd_last <= '0;   wr_last <= '0;
      pend    <= 1'b0; pend_id <= '0;
      bus_err <= 1'b0;
    end else begin
      if (arvalid && arready) arvalid <= 1'b0;
      if (rd_pick[PW]) begin
        arvalid <= 1'b1; araddr <= ar_addr_n; arid <= ar_id_n; arsize <= ar_size_n;
        rd_last <= rd_pick[PW-1:0];
      end
      if (awvalid && awready) awvalid <= 1'b0;
      if (wvalid && wready) wvalid <= 1'b0;
      if (wr_pick[PW]) begin
        awvalid <= 1'b1; awaddr <= aw_addr_n; awid <= aw_id_n; awsize <= aw_size_n;
        wvalid  <= 1'b1; wdata  <= w_data_n;  wstrb <= w_strb_n;
        wr_last <= wr_pick[PW-1:0];
      end
      if (rd_pick[PW] && !rd_dec) rd_cnt <= rd_cnt + 1'b1;
      else if (!rd_pick[PW] && rd_dec) rd_cnt <= rd_cnt - 1'b1;
      if (wr_pick[PW] && !wr_dec) wr_cnt <= wr_cnt + 1'b1;
      else if (!wr_pick[PW] && wr_dec) wr_cnt <= wr_cnt - 1'b1;
      if (b_conflict) begin
        pend <= 1'b1; pend_id <= bid;
      end else if (pend_fire) begin
        pend <= 1'b0;
      end
      if ((rvalid && rresp != RESP_OKAY) || (bvalid && bresp != RESP_OKAY)) bus_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_axi_sram_bridge_mp.sv
// Directed bench for axi_sram_bridge_mp: a fixed-priority instance plus a
// round-robin instance sharing the same stimulus.
module tb_axi_sram_bridge_mp;
  localparam int NP = 2;

  logic clk = 1'b0;
  logic resetn;
  logic [NP-1:0] sram_req, sram_wr;
  logic [2*NP-1:0] sram_size;
  logic [32*NP-1:0] sram_addr, sram_wdata;
  logic [4*NP-1:0] sram_wstrb;
  logic arready, rlast, rvalid, awready, wready, bvalid;
  logic [3:0] rid, bid;
  logic [31:0] rdata;
  logic [1:0] rresp, bresp;

  logic [NP-1:0] addr_ok, data_ok;
  logic [31:0] s_rdata, araddr, awaddr, wdata;
  logic bus_err, arvalid, rready, awvalid, wlast, wvalid, bready;
  logic [3:0] arid, arlen, arcache, awid, awlen, awcache, wid, wstrb;
  logic [2:0] arsize, arprot, awsize, awprot;
  logic [1:0] arburst, arlock, awburst, awlock;

  logic [NP-1:0] rr_addr_ok, rr_data_ok;
  logic [31:0] rr_rdata, rr_araddr, rr_awaddr, rr_wdata;
  logic rr_bus_err, rr_arvalid, rr_rready, rr_awvalid, rr_wlast, rr_wvalid, rr_bready;
  logic [3:0] rr_arid, rr_arlen, rr_arcache, rr_awid, rr_awlen, rr_awcache, rr_wid, rr_wstrb;
  logic [2:0] rr_arsize, rr_arprot, rr_awsize, rr_awprot;
  logic [1:0] rr_arburst, rr_arlock, rr_awburst, rr_awlock;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_sram_bridge_mp #(.NUM_PORTS(NP), .MAX_OUTST(4), .ARB_RR(0)) dut (
    .clk(clk), .resetn(resetn),
    .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size), .sram_addr(sram_addr),
    .sram_wstrb(sram_wstrb), .sram_wdata(sram_wdata),
    .sram_addr_ok(addr_ok), .sram_data_ok(data_ok), .sram_rdata(s_rdata), .bus_err(bus_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  axi_sram_bridge_mp #(.NUM_PORTS(NP), .MAX_OUTST(4), .ARB_RR(1)) dut_rr (
    .clk(clk), .resetn(resetn),
    .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size), .sram_addr(sram_addr),
    .sram_wstrb(sram_wstrb), .sram_wdata(sram_wdata),
    .sram_addr_ok(rr_addr_ok), .sram_data_ok(rr_data_ok), .sram_rdata(rr_rdata), .bus_err(rr_bus_err),
    .arid(rr_arid), .araddr(rr_araddr), .arlen(rr_arlen), .arsize(rr_arsize), .arburst(rr_arburst),
    .arlock(rr_arlock), .arcache(rr_arcache), .arprot(rr_arprot), .arvalid(rr_arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rr_rready),
    .awid(rr_awid), .awaddr(rr_awaddr), .awlen(rr_awlen), .awsize(rr_awsize), .awburst(rr_awburst),
    .awlock(rr_awlock), .awcache(rr_awcache), .awprot(rr_awprot), .awvalid(rr_awvalid), .awready(awready),
    .wid(rr_wid), .wdata(rr_wdata), .wstrb(rr_wstrb), .wlast(rr_wlast), .wvalid(rr_wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(rr_bready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic set_port(input int p, input logic req, input logic wr,
                          input logic [31:0] addr, input logic [31:0] data);
    sram_req[p] = req;
    sram_wr[p] = wr;
    sram_addr[32*p +: 32] = addr;
    sram_wdata[32*p +: 32] = data;
    sram_wstrb[4*p +: 4] = 4'hf;
    sram_size[2*p +: 2] = 2'd2;
  endtask

  task automatic clear_in();
    sram_req = '0; sram_wr = '0; sram_size = '0; sram_addr = '0; sram_wdata = '0; sram_wstrb = '0;
    arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0; rlast = 1;
    rid = '0; bid = '0; rdata = '0; rresp = '0; bresp = '0;
  endtask

  task automatic do_reset();
    tick();
    resetn = 0;
    clear_in();
    tick();
    resetn = 1;
  endtask

  initial begin
    resetn = 0;
    clear_in();
    repeat (2) tick();
    at_neg();
    chk("rst_arvalid", 32'(arvalid), 32'h0);
    chk("rst_awvalid", 32'(awvalid), 32'h0);
    chk("rst_wvalid", 32'(wvalid), 32'h0);
    chk("rst_addr_ok", 32'(addr_ok), 32'h0);
    chk("rst_data_ok", 32'(data_ok), 32'h0);
    chk("rst_bus_err", 32'(bus_err), 32'h0);
    chk("const_arlen_arburst", {26'h0, arlen, arburst}, 32'h1);
    chk("const_wlast_rready_bready", {29'h0, wlast, rready, bready}, 32'h7);
    tick();
    resetn = 1;

    // single read on port 1 with arready after three cycles
    tick(); set_port(1, 1, 0, 32'h1000, 0); at_neg();
    chk("t1_addr_ok", 32'(addr_ok), 32'h2);
    tick(); set_port(1, 0, 0, 0, 0); at_neg();
    chk("t1_arvalid_c1", 32'(arvalid), 32'h1);
    chk("t1_araddr", araddr, 32'h1000);
    chk("t1_arid", 32'(arid), 32'h1);
    chk("t1_arsize", 32'(arsize), 32'h2);
    tick(); at_neg();
    chk("t1_arvalid_c2", 32'(arvalid), 32'h1);
    chk("t1_araddr_c2", araddr, 32'h1000);
    tick(); arready = 1; at_neg();
    chk("t1_arvalid_c3", 32'(arvalid), 32'h1);
    tick(); arready = 0; rvalid = 1; rid = 4'd1; rdata = 32'hDEADBEEF; at_neg();
    chk("t1_arvalid_drop", 32'(arvalid), 32'h0);
    chk("t1_data_ok", 32'(data_ok), 32'h2);
    chk("t1_rdata", s_rdata, 32'hDEADBEEF);
    tick(); rvalid = 0; at_neg();
    chk("t1_data_ok_clr", 32'(data_ok), 32'h0);
    do_reset();

    // both ports read every cycle: fixed always picks 1, RR alternates 1,0,1,0
    tick(); arready = 1; set_port(0, 1, 0, 32'h100, 0); set_port(1, 1, 0, 32'h200, 0); at_neg();
    chk("t2_fix_r0", 32'(addr_ok), 32'h2);
    chk("t2_rr_r0", 32'(rr_addr_ok), 32'h2);
    tick(); at_neg();
    chk("t2_fix_r1", 32'(addr_ok), 32'h2);
    chk("t2_fix_arid", 32'(arid), 32'h1);
    chk("t2_rr_r1", 32'(rr_addr_ok), 32'h1);
    chk("t2_rr_arid_r0", 32'(rr_arid), 32'h1);
    tick(); at_neg();
    chk("t2_rr_r2", 32'(rr_addr_ok), 32'h2);
    chk("t2_rr_arid_r1", 32'(rr_arid), 32'h0);
    chk("t2_rr_araddr_r1", rr_araddr, 32'h100);
    tick(); at_neg();
    chk("t2_rr_r3", 32'(rr_addr_ok), 32'h1);
    chk("t2_rr_arid_r2", 32'(rr_arid), 32'h1);
    chk("t2_fix_r3", 32'(addr_ok), 32'h2);
    tick(); sram_req = '0; at_neg();
    chk("t2_rr_arid_r3", 32'(rr_arid), 32'h0);
    do_reset();

    // RAW: write port1 0x2000 and read port0 0x2000 in the same cycle
    tick(); awready = 1; wready = 1; arready = 1;
    set_port(1, 1, 1, 32'h2000, 32'h11223344); set_port(0, 1, 0, 32'h2000, 0); at_neg();
    chk("t3_wr_only_grant", 32'(addr_ok), 32'h2);
    tick(); set_port(1, 0, 0, 0, 0); at_neg();
    chk("t3_awvalid", 32'(awvalid), 32'h1);
    chk("t3_wvalid", 32'(wvalid), 32'h1);
    chk("t3_awaddr", awaddr, 32'h2000);
    chk("t3_awid_wid", {24'h0, awid, wid}, 32'h11);
    chk("t3_wdata", wdata, 32'h11223344);
    chk("t3_wstrb", 32'(wstrb), 32'hf);
    chk("t3_raw_block1", 32'(addr_ok), 32'h0);
    tick(); at_neg();
    chk("t3_aw_done", 32'(awvalid), 32'h0);
    chk("t3_raw_block2", 32'(addr_ok), 32'h0);
    tick(); set_port(0, 1, 0, 32'h2004, 0); at_neg();
    chk("t3_other_word", 32'(addr_ok), 32'h1);
    tick(); set_port(0, 1, 0, 32'h2000, 0); bvalid = 1; bid = 4'd1; at_neg();
    chk("t3_block_during_b", 32'(addr_ok), 32'h0);
    chk("t3_b_data_ok", 32'(data_ok), 32'h2);
    tick(); bvalid = 0; at_neg();
    chk("t3_rd_after_b", 32'(addr_ok), 32'h1);
    do_reset();

    // AW accepted in cycle 1, W in cycle 4; next write waits until cycle 5
    tick(); set_port(1, 1, 1, 32'h3000, 32'hCAFEF00D); at_neg();
    chk("t4_grant", 32'(addr_ok), 32'h2);
    tick(); awready = 1; at_neg();
    chk("t4_c1_valids", {30'h0, awvalid, wvalid}, 32'h3);
    chk("t4_c1_no_new", 32'(addr_ok), 32'h0);
    tick(); awready = 0; at_neg();
    chk("t4_c2_valids", {30'h0, awvalid, wvalid}, 32'h1);
    chk("t4_c2_no_new", 32'(addr_ok), 32'h0);
    tick(); at_neg();
    chk("t4_c3_wvalid", 32'(wvalid), 32'h1);
    chk("t4_c3_no_new", 32'(addr_ok), 32'h0);
    tick(); wready = 1; at_neg();
    chk("t4_c4_wvalid", 32'(wvalid), 32'h1);
    chk("t4_c4_no_new", 32'(addr_ok), 32'h0);
    tick(); wready = 0; at_neg();
    chk("t4_c5_wvalid", 32'(wvalid), 32'h0);
    chk("t4_c5_new_write", 32'(addr_ok), 32'h2);
    do_reset();

    // read outstanding limit of 4 with rvalid withheld
    tick(); arready = 1; set_port(0, 1, 0, 32'h4000, 0);
    for (int k = 0; k < 4; k++) begin
      at_neg();
      chk($sformatf("t5_grant%0d", k), 32'(addr_ok), 32'h1);
      tick();
    end
    at_neg();
    chk("t5_limit_a", 32'(addr_ok), 32'h0);
    tick(); at_neg();
    chk("t5_limit_b", 32'(addr_ok), 32'h0);
    tick(); rvalid = 1; rid = 4'd0; rdata = 32'h55; at_neg();
    chk("t5_limit_r", 32'(addr_ok), 32'h0);
    chk("t5_r_data_ok", 32'(data_ok), 32'h1);
    tick(); rvalid = 0; at_neg();
    chk("t5_after_r", 32'(addr_ok), 32'h1);
    tick(); sram_req = '0;
    do_reset();

    // R and B to the same port in one cycle give two data_ok pulses
    tick(); arready = 1; awready = 1; wready = 1; set_port(1, 1, 1, 32'h5000, 32'hA5A5A5A5); at_neg();
    chk("t6_wr_grant", 32'(addr_ok), 32'h2);
    tick(); set_port(1, 1, 0, 32'h6000, 0); at_neg();
    chk("t6_rd_grant", 32'(addr_ok), 32'h2);
    tick(); set_port(1, 0, 0, 0, 0); rvalid = 1; rid = 4'd1; rdata = 32'h77;
    bvalid = 1; bid = 4'd1; bresp = 2'b00; at_neg();
    chk("t6_pulse1", 32'(data_ok), 32'h2);
    chk("t6_rdata", s_rdata, 32'h77);
    tick(); rvalid = 0; bvalid = 0; at_neg();
    chk("t6_pulse2", 32'(data_ok), 32'h2);
    tick(); at_neg();
    chk("t6_idle", 32'(data_ok), 32'h0);

    // error response sets sticky bus_err
    tick(); set_port(1, 1, 1, 32'h7000, 32'h1); at_neg();
    chk("t7_wr_grant", 32'(addr_ok), 32'h2);
    tick(); set_port(1, 0, 0, 0, 0);
    tick(); bvalid = 1; bid = 4'd1; bresp = 2'b10; at_neg();
    chk("t7_err_before", 32'(bus_err), 32'h0);
    tick(); bvalid = 0; bresp = 2'b00; at_neg();
    chk("t7_err_set", 32'(bus_err), 32'h1);
    tick(); tick(); at_neg();
    chk("t7_err_sticky", 32'(bus_err), 32'h1);

    // reset while an AR is pending drops it and clears counters
    tick(); arready = 0; set_port(0, 1, 0, 32'h8000, 0); at_neg();
    chk("t8_grant", 32'(addr_ok), 32'h1);
    tick(); set_port(0, 0, 0, 0, 0); at_neg();
    chk("t8_ar_pending", 32'(arvalid), 32'h1);
    tick(); resetn = 0;
    tick(); resetn = 1; at_neg();
    chk("t8_arvalid_cleared", 32'(arvalid), 32'h0);
    chk("t8_bus_err_cleared", 32'(bus_err), 32'h0);
    chk("t8_awvalid_cleared", 32'(awvalid), 32'h0);
    tick(); arready = 1; set_port(0, 1, 0, 32'h9000, 0);
    for (int k = 0; k < 4; k++) begin
      at_neg();
      chk($sformatf("t8_cnt_grant%0d", k), 32'(addr_ok), 32'h1);
      tick();
    end
    at_neg();
    chk("t8_cnt_limit", 32'(addr_ok), 32'h0);
    tick(); sram_req = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
